// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if
// Bundles the command/response handshake and the APB bus seen by the bridge.
//   cmd_*  : requester -> bridge command (valid/ready handshake)
//   rsp_*  : bridge -> requester one-cycle response pulse, plus err_cnt
//   p*     : APB requester-side signals (psel/penable/pwrite/paddr/pwdata out,
//            pready/pslverr/prdata in)
// Modport master is the bridge's view; modport slave is the environment's view
// (command source, response sink and APB completer).
interface apb_master_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic [15:0]       err_cnt;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic              pslverr;
  logic [DATA_W-1:0] prdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  pready, pslverr, prdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout, err_cnt,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output pready, pslverr, prdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout, err_cnt,
    input  psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master_bridge.sv
// apb_master_bridge
// Converts single valid/ready commands into APB transfers (IDLE -> SETUP ->
// ACCESS) and returns a one-cycle response pulse. An ACCESS phase that waits
// TIMEOUT cycles without pready is aborted and reported as a timeout error.
// Ports:
//   pclk : clock, all state on the rising edge
//   prst : synchronous active-low reset
//   bus  : apb_master_bridge_if.master (command, response, err_cnt, APB)
// Every output is a register; nothing depends combinationally on an input.
module apb_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                pclk,
  input  logic                prst,
  apb_master_bridge_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  // Counter value on the edge that would make it reach TIMEOUT.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              accept, done_ok, done_to, err_ev;
  logic [7:0]        wait_q;

  logic              cmd_ready_q;
  logic              psel_q, penable_q, pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              rsp_valid_q, rsp_err_q, rsp_timeout_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [15:0]       err_cnt_q;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge pclk) begin
    if (!prst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // pready wins over the timeout when both land on the same edge.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done_ok = 1'b0;
    done_to = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          accept  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (bus.pready) begin
          done_ok = 1'b1;
          state_d = IDLE;
        end else if (wait_q == TO_LAST) begin
          done_to = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    err_ev = done_to | (done_ok & bus.pslverr);
  end

  // Output register stage: APB controls follow the next state so they are
  // valid for the whole cycle the FSM spends in that state.
  always_ff @(posedge pclk) begin
    if (!prst) begin
      cmd_ready_q   <= 1'b1;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      wait_q        <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
      err_cnt_q     <= '0;
    end else begin
      cmd_ready_q <= (state_d == IDLE);
      psel_q      <= (state_d != IDLE);
      penable_q   <= (state_d == ACCESS);
      if (accept) begin
        paddr_q  <= bus.cmd_addr;
        pwdata_q <= bus.cmd_wdata;
        pwrite_q <= bus.cmd_write;
        wait_q   <= '0;
      end else if (state_q == ACCESS && !bus.pready) begin
        wait_q <= wait_q + 8'd1;
      end
      rsp_valid_q   <= done_ok | done_to;
      rsp_err_q     <= err_ev;
      rsp_timeout_q <= done_to;
      rsp_rdata_q   <= (done_ok && !pwrite_q && !bus.pslverr) ? bus.prdata : '0;
      if (err_ev) err_cnt_q <= sat_inc16(err_cnt_q);
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge
// Directed bench for apb_master_bridge: a table of single transfers with a
// behavioural APB completer, plus hand sequences for back-to-back accepts,
// reset during ACCESS and err_cnt saturation.
module tb_apb_master_bridge;

  logic pclk = 1'b0;
  logic prst;
  always #5 pclk = ~pclk;

  apb_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .pclk (pclk),
    .prst (prst),
    .bus  (bus.master)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    int          wt;       // ACCESS cycles before pready (255 = never)
    logic        slverr;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic        exp_to;
    int          exp_acc;  // ACCESS cycles expected
    logic [15:0] exp_ec;   // err_cnt expected after the response
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Runs one transfer; returns at #1 after the edge that raised the response.
  task automatic do_txn(input vec_t v, output int acc, output logic rv,
                        output logic [31:0] rd, output logic re, output logic rt,
                        output logic stable);
    int guard;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = v.wr;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    guard = 0;
    while (!bus.cmd_ready && guard < 50) begin
      @(posedge pclk); #1; guard++;
    end
    @(posedge pclk); #1;               // accept edge k, now in SETUP
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = 32'h5555_5555;     // requester side may change freely now
    bus.cmd_wdata = 32'h6666_6666;
    bus.cmd_write = ~v.wr;
    stable = bus.psel && !bus.penable && bus.paddr == v.addr &&
             bus.pwrite == v.wr && (!v.wr || bus.pwdata == v.wdata);
    @(posedge pclk); #1;               // first ACCESS cycle
    acc = 0;
    while (bus.psel && acc < 300) begin
      stable = stable && bus.penable && bus.paddr == v.addr &&
               bus.pwrite == v.wr && (!v.wr || bus.pwdata == v.wdata);
      bus.pready  = (acc >= v.wt);
      bus.pslverr = bus.pready ? v.slverr : 1'b1;   // must be ignored while waiting
      bus.prdata  = bus.pready ? v.prdata : 32'hFFFF_0000;
      @(posedge pclk); #1;
      acc++;
      bus.pready  = 1'b0;
      bus.pslverr = 1'b0;
      bus.prdata  = 32'h0BAD_0BAD;
    end
    rv = bus.rsp_valid;
    rd = bus.rsp_rdata;
    re = bus.rsp_err;
    rt = bus.rsp_timeout;
    stable = stable && !bus.penable;
  endtask

  vec_t vecs [8];

  initial begin
    int acc;
    logic rv, re, rt, st;
    logic [31:0] rd;
    int na, nr, cyc, guard;
    int t [4];

    vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 32'h1111_1111, 0,   1'b0, 32'h0,        1'b0, 1'b0, 1,  16'd0};
    vecs[1] = '{1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 3,   1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 4,  16'd0};
    vecs[2] = '{1'b0, 32'h40, 32'h0,        32'h7777_7777, 0,   1'b1, 32'h0,        1'b1, 1'b0, 1,  16'd1};
    vecs[3] = '{1'b0, 32'h80, 32'h0,        32'h1234_5678, 255, 1'b0, 32'h0,        1'b1, 1'b1, 16, 16'd2};
    vecs[4] = '{1'b0, 32'h84, 32'h0,        32'hCAFEF00D, 15,  1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 16, 16'd2};
    vecs[5] = '{1'b1, 32'h88, 32'h0000_00A5, 32'h2222_2222, 2,   1'b1, 32'h0,        1'b1, 1'b0, 3,  16'd3};
    vecs[6] = '{1'b1, 32'h8C, 32'h0000_005A, 32'h3333_3333, 255, 1'b0, 32'h0,        1'b1, 1'b1, 16, 16'd4};
    vecs[7] = '{1'b0, 32'hF0, 32'h0,        32'hA5A5_5A5A, 1,   1'b0, 32'hA5A5_5A5A, 1'b0, 1'b0, 2,  16'd4};

    prst          = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h0;
    bus.cmd_wdata = 32'h0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
    bus.prdata    = 32'h0;

    // Reset state
    repeat (2) @(posedge pclk);
    #1;
    chk("rst_psel",    32'(bus.psel), 32'd0);
    chk("rst_penable", 32'(bus.penable), 32'd0);
    chk("rst_pwrite",  32'(bus.pwrite), 32'd0);
    chk("rst_paddr",   bus.paddr, 32'd0);
    chk("rst_pwdata",  bus.pwdata, 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_rsp_to",  32'(bus.rsp_timeout), 32'd0);
    chk("rst_rdata",   bus.rsp_rdata, 32'd0);
    chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    prst = 1'b1;
    @(posedge pclk); #1;
    chk("rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Table of single transfers
    for (int i = 0; i < 8; i++) begin
      do_txn(vecs[i], acc, rv, rd, re, rt, st);
      chk($sformatf("v%0d_rsp_valid", i), 32'(rv), 32'd1);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("v%0d_err", i), 32'(re), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_timeout", i), 32'(rt), 32'(vecs[i].exp_to));
      chk($sformatf("v%0d_access_cycles", i), 32'(acc), 32'(vecs[i].exp_acc));
      chk($sformatf("v%0d_bus_stable", i), 32'(st), 32'd1);
      chk($sformatf("v%0d_err_cnt", i), 32'(bus.err_cnt), 32'(vecs[i].exp_ec));
      @(posedge pclk); #1;
      chk($sformatf("v%0d_rsp_pulse_end", i), 32'(bus.rsp_valid), 32'd0);
    end

    // Back-to-back: cmd_valid held high for 4 writes, completer always ready
    bus.pready    = 1'b1;
    bus.pslverr   = 1'b0;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h100;
    bus.cmd_wdata = 32'h0;
    guard = 0;
    while (!bus.cmd_ready && guard < 50) begin
      @(posedge pclk); #1; guard++;
    end
    bus.cmd_valid = 1'b1;
    na = 0; nr = 0;
    for (cyc = 0; cyc < 20; cyc++) begin
      if (bus.cmd_valid && bus.cmd_ready) begin
        if (na < 4) t[na] = cyc;
        na++;
      end
      if (bus.rsp_valid) nr++;
      @(posedge pclk); #1;
      if (na >= 4) bus.cmd_valid = 1'b0;
      bus.cmd_addr = 32'h100 + 32'(na) * 32'd4;
    end
    bus.pready = 1'b0;
    chk("b2b_accepts", 32'(na), 32'd4);
    chk("b2b_gap01", 32'(t[1] - t[0]), 32'd3);
    chk("b2b_gap12", 32'(t[2] - t[1]), 32'd3);
    chk("b2b_gap23", 32'(t[3] - t[2]), 32'd3);
    chk("b2b_responses", 32'(nr), 32'd4);
    chk("b2b_err_cnt", 32'(bus.err_cnt), 32'd4);

    // Reset while in ACCESS: silent abort
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h200;
    bus.cmd_wdata = 32'h1234_ABCD;
    @(posedge pclk); #1;               // accept
    bus.cmd_valid = 1'b0;
    @(posedge pclk); #1;               // ACCESS
    @(posedge pclk); #1;               // still ACCESS, pready low
    chk("ar_in_access", 32'({bus.psel, bus.penable}), 32'd3);
    prst = 1'b0;
    @(posedge pclk); #1;
    chk("ar_psel",    32'(bus.psel), 32'd0);
    chk("ar_penable", 32'(bus.penable), 32'd0);
    chk("ar_pwrite",  32'(bus.pwrite), 32'd0);
    chk("ar_paddr",   bus.paddr, 32'd0);
    chk("ar_pwdata",  bus.pwdata, 32'd0);
    chk("ar_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("ar_err_cnt", 32'(bus.err_cnt), 32'd0);
    prst = 1'b1;
    nr = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge pclk); #1;
      if (bus.rsp_valid) nr++;
    end
    chk("ar_no_rsp", 32'(nr), 32'd0);
    chk("ar_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // err_cnt saturation from a preloaded 0xFFFF
    force dut.err_cnt_q = 16'hFFFF;
    #1;
    release dut.err_cnt_q;
    #1;
    chk("sat_preload", 32'(bus.err_cnt), 32'h0000_FFFF);
    do_txn(vecs[2], acc, rv, rd, re, rt, st);
    chk("sat_rsp_err", 32'(re), 32'd1);
    chk("sat_err_cnt", 32'(bus.err_cnt), 32'h0000_FFFF);
    do_txn(vecs[6], acc, rv, rd, re, rt, st);
    chk("sat_err_cnt2", 32'(bus.err_cnt), 32'h0000_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
